// File: rtl/mau_pkg.sv
// ----------------------------------------------------------------------------
// mau_pkg
//   Shared types for the memory access unit: FSM state encoding, the latched
//   data-memory request record, and a small alignment helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package mau_pkg;

    localparam int unsigned MAU_DATA_W = 32;
    localparam int unsigned MAU_ADDR_W = 32;
    localparam int unsigned MAU_LANES  = MAU_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } mau_state_e;

    typedef struct packed {
        logic [MAU_ADDR_W-1:0] addr;
        logic                  we;
        logic [MAU_LANES-1:0]  mask;
        logic [MAU_DATA_W-1:0] data;
    } mem_req_s;

    // Word accesses must sit on a 4-byte boundary; byte accesses never fault.
    function automatic logic misaligned_word(input logic is_byte, input logic [1:0] lane);
        return !is_byte && (lane != 2'b00);
    endfunction

endpackage

// File: rtl/mau_byte_lane.sv
// ----------------------------------------------------------------------------
// mau_byte_lane
//   Purely combinational byte-lane logic for the memory access unit.
//   Store side: builds the byte write mask and replicated write data (SB/SW).
//   Load side : selects and zero-extends one byte of the returned word (LBU)
//               or passes the full word through (LW).
// Ports
//   st_byte_i  in  store is a byte op (SB)
//   st_lane_i  in  store byte lane (addr[1:0])
//   st_data_i  in  raw store data
//   st_mask_o  out byte write enables
//   st_data_o  out lane-steered write data
//   ld_byte_i  in  load is a byte op (LBU)
//   ld_lane_i  in  load byte lane (addr[1:0])
//   ld_word_i  in  full word returned by memory
//   ld_data_o  out load result for write-back
// ----------------------------------------------------------------------------
module mau_byte_lane
    import mau_pkg::*;
(
    input  logic                  st_byte_i,
    input  logic [1:0]            st_lane_i,
    input  logic [MAU_DATA_W-1:0] st_data_i,
    output logic [MAU_LANES-1:0]  st_mask_o,
    output logic [MAU_DATA_W-1:0] st_data_o,
    input  logic                  ld_byte_i,
    input  logic [1:0]            ld_lane_i,
    input  logic [MAU_DATA_W-1:0] ld_word_i,
    output logic [MAU_DATA_W-1:0] ld_data_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        st_mask_o = '1;
        st_data_o = st_data_i;
        if (st_byte_i) begin
            st_mask_o = MAU_LANES'(1) << st_lane_i;
            // Replicating the byte into every lane lets memory pick it up
            // from whichever lane the mask enables.
            st_data_o = {MAU_LANES{st_data_i[7:0]}};
        end
    end

    always_comb begin
        ld_data_o = ld_word_i;
        if (ld_byte_i) begin
            ld_data_o = {{(MAU_DATA_W-8){1'b0}}, ld_word_i[{ld_lane_i, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//   Memory stage of the core. Takes decoded load/store/byte flags plus the
//   effective address and store data, issues one data-memory request per
//   instruction over a valid/yumi handshake, and returns load data to the
//   register file. busy_o holds the upstream pipeline until completion.
//   Misaligned word accesses and handshake timeouts raise a one-cycle err_o.
// Ports
//   clk, reset                      core clock, synchronous active-high reset
//   valid_i, is_load_op_i,
//   is_store_op_i, is_byte_op_i     instruction present + decode flags
//   addr_i, st_data_i, rd_i         effective address, store data, load dest
//   busy_o                          unit is not idle
//   req_valid_o/addr/we/mask/data   dmem request (held until req_yumi_i)
//   req_yumi_i                      dmem accepted the request
//   resp_valid_i, resp_data_i       dmem read response
//   wb_valid_o, wb_rd_o, wb_data_o  one-cycle load write-back
//   err_o                           one-cycle misalignment/timeout pulse
// ----------------------------------------------------------------------------
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned DATA_W      = MAU_DATA_W,
    parameter int unsigned ADDR_W      = MAU_ADDR_W,
    parameter int unsigned RD_W        = 5,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              is_load_op_i,
    input  logic              is_store_op_i,
    input  logic              is_byte_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              busy_o,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              req_we_o,
    output logic [3:0]        req_mask_o,
    output logic [DATA_W-1:0] req_data_o,
    input  logic              req_yumi_i,
    input  logic              resp_valid_i,
    input  logic [DATA_W-1:0] resp_data_i,
    output logic              wb_valid_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mau_state_e        state_q,     state_d;
    mem_req_s          req_q,       req_d;
    logic              req_valid_q, req_valid_d;
    logic              ld_byte_q,   ld_byte_d;
    logic [1:0]        ld_lane_q,   ld_lane_d;
    logic [RD_W-1:0]   rd_q,        rd_d;
    logic [TMR_W-1:0]  timer_q,     timer_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q,     wb_rd_d;
    logic [DATA_W-1:0] wb_data_q,   wb_data_d;
    logic              err_q,       err_d;

    // ------------------------------------------------------------------
    // Byte-lane steering
    // ------------------------------------------------------------------
    logic [3:0]        st_mask;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_data;

    // Store side steers the incoming instruction; load side extracts from
    // the response using the lane captured when the load was accepted.
    mau_byte_lane u_byte_lane (
        .st_byte_i (is_byte_op_i),
        .st_lane_i (addr_i[1:0]),
        .st_data_i (st_data_i),
        .st_mask_o (st_mask),
        .st_data_o (st_data),
        .ld_byte_i (ld_byte_q),
        .ld_lane_i (ld_lane_q),
        .ld_word_i (resp_data_i),
        .ld_data_o (ld_data)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic mem_op;
    logic timed_out;

    assign mem_op    = valid_i && (is_load_op_i || is_store_op_i);
    assign timed_out = (timer_q == TMR_LAST);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        req_valid_d = req_valid_q;
        ld_byte_d   = ld_byte_q;
        ld_lane_d   = ld_lane_q;
        rd_d        = rd_q;
        timer_d     = timer_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned_word(is_byte_op_i, addr_i[1:0])) begin
                        // Fault without touching memory; stay idle.
                        err_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        timer_d     = '0;
                        req_d.addr  = {addr_i[ADDR_W-1:2], 2'b00};
                        req_d.we    = is_store_op_i;
                        // Loads write nothing, so they carry an empty mask.
                        req_d.mask  = is_store_op_i ? st_mask : 4'b0000;
                        req_d.data  = is_store_op_i ? st_data : '0;
                        ld_byte_d   = is_byte_op_i;
                        ld_lane_d   = addr_i[1:0];
                        rd_d        = rd_i;
                    end
                end
            end

            REQ: begin
                // A response arriving alongside yumi belongs to no request
                // of ours yet, so it is ignored here.
                if (req_yumi_i) begin
                    req_valid_d = 1'b0;
                    timer_d     = '0;
                    state_d     = req_q.we ? IDLE : WAIT_RESP;
                end else if (timed_out) begin
                    req_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            WAIT_RESP: begin
                if (resp_valid_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = ld_data;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            ld_byte_q   <= 1'b0;
            ld_lane_q   <= 2'b00;
            rd_q        <= '0;
            timer_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            ld_byte_q   <= ld_byte_d;
            ld_lane_q   <= ld_lane_d;
            rd_q        <= rd_d;
            timer_q     <= timer_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all taken straight from flops)
    // ------------------------------------------------------------------
    assign busy_o      = (state_q != IDLE);
    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_q.addr;
    assign req_we_o    = req_q.we;
    assign req_mask_o  = req_q.mask;
    assign req_data_o  = req_q.data;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, is_load_op_i, is_store_op_i, is_byte_op_i;
    logic [31:0] addr_i, st_data_i;
    logic [4:0]  rd_i;
    logic        busy_o, req_valid_o, req_we_o;
    logic [31:0] req_addr_o, req_data_o;
    logic [3:0]  req_mask_o;
    logic        req_yumi_i, resp_valid_i;
    logic [31:0] resp_data_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (valid_i),
        .is_load_op_i (is_load_op_i),
        .is_store_op_i(is_store_op_i),
        .is_byte_op_i (is_byte_op_i),
        .addr_i       (addr_i),
        .st_data_i    (st_data_i),
        .rd_i         (rd_i),
        .busy_o       (busy_o),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_we_o     (req_we_o),
        .req_mask_o   (req_mask_o),
        .req_data_o   (req_data_o),
        .req_yumi_i   (req_yumi_i),
        .resp_valid_i (resp_valid_i),
        .resp_data_i  (resp_data_i),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic [31:0] resp;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_data;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are examined 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic byt,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd);
        valid_i       = 1'b1;
        is_load_op_i  = ld;
        is_store_op_i = st;
        is_byte_op_i  = byt;
        addr_i        = addr;
        st_data_i     = data;
        rd_i          = rd;
        tick();
        valid_i       = 1'b0;
        is_load_op_i  = 1'b0;
        is_store_op_i = 1'b0;
        is_byte_op_i  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        present(v.ld, v.st, v.byt, v.addr, v.st_data, v.rd);
        if (v.exp_err) begin
            check("misalign err", err_o, 1);
            check("misalign no req", req_valid_o, 0);
            check("misalign busy", busy_o, 0);
            tick();
            check("misalign err pulse", err_o, 0);
            return;
        end
        check("req valid", req_valid_o, 1);
        check("req addr", req_addr_o, v.exp_addr);
        check("req we", req_we_o, v.st);
        check("busy", busy_o, 1);
        if (v.st) begin
            check("req mask", req_mask_o, v.exp_mask);
            check("req data", req_data_o, v.exp_data);
        end
        req_yumi_i = 1'b1;
        tick();
        req_yumi_i = 1'b0;
        check("req drop", req_valid_o, 0);
        if (v.st) begin
            check("store done busy", busy_o, 0);
            check("store no wb", wb_valid_o, 0);
        end else begin
            check("load wait busy", busy_o, 1);
            resp_valid_i = 1'b1;
            resp_data_i  = v.resp;
            tick();
            resp_valid_i = 1'b0;
            check("wb valid", wb_valid_o, 1);
            check("wb data", wb_data_o, v.exp_wb);
            check("wb rd", wb_rd_o, v.rd);
            check("load done busy", busy_o, 0);
            tick();
            check("wb pulse", wb_valid_o, 0);
        end
    endtask

    initial begin
        int n;

        //            ld    st    byt   addr          st_data       rd     resp          err   exp_addr      mask  exp_data      exp_wb
        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_005A, 5'd0,  32'h0,        1'b0, 32'h0000_0200, 4'h8, 32'h5A5A_5A5A, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_1001, 32'h1234_56C3, 5'd0,  32'h0,        1'b0, 32'h0000_1000, 4'h2, 32'hC3C3_C3C3, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  32'h0,        1'b0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0041, 32'h0,         5'd7,  32'h1122_3344, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h0000_0033};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0043, 32'h0,         5'd31, 32'hA1B2_C3D4, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h0000_00A1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0,         5'd1,  32'h0000_00FF, 1'b0, 32'h0000_0080, 4'h0, 32'h0,         32'h0000_00FF};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0084, 32'h0,         5'd9,  32'hCAFE_F00D, 1'b0, 32'h0000_0084, 4'h0, 32'h0,         32'hCAFE_F00D};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_0042, 32'h0,         5'd2,  32'h0,        1'b1, 32'h0,         4'h0, 32'h0,         32'h0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0101, 32'h1111_1111, 5'd0,  32'h0,        1'b1, 32'h0,         4'h0, 32'h0,         32'h0};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0000_0077, 5'd0,  32'h0,        1'b0, 32'h0000_0100, 4'h4, 32'h7777_7777, 32'h0};

        reset = 1'b1;
        valid_i = 1'b0; is_load_op_i = 1'b0; is_store_op_i = 1'b0; is_byte_op_i = 1'b0;
        addr_i = '0; st_data_i = '0; rd_i = '0;
        req_yumi_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst busy", busy_o, 0);
        check("rst req_valid", req_valid_o, 0);
        check("rst we", req_we_o, 0);
        check("rst mask", req_mask_o, 0);
        check("rst addr", req_addr_o, 0);
        check("rst data", req_data_o, 0);
        check("rst wb_valid", wb_valid_o, 0);
        check("rst err", err_o, 0);

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Non-memory instruction and idle response are ignored
        resp_valid_i = 1'b1;
        present(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 5'd3);
        resp_valid_i = 1'b0;
        check("nonmem busy", busy_o, 0);
        check("nonmem req", req_valid_o, 0);
        check("idle resp no wb", wb_valid_o, 0);

        // SW held for two cycles before yumi
        present(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd0);
        check("hold c1 valid", req_valid_o, 1);
        tick();
        check("hold c2 valid", req_valid_o, 1);
        check("hold c2 addr", req_addr_o, 32'h100);
        check("hold c2 mask", req_mask_o, 4'hF);
        check("hold c2 data", req_data_o, 32'hDEAD_BEEF);
        check("hold c2 we", req_we_o, 1);
        // Present a new store on the completion cycle: it must not be taken.
        req_yumi_i = 1'b1;
        valid_i = 1'b1; is_store_op_i = 1'b1; addr_i = 32'h500; st_data_i = 32'h1;
        tick();
        req_yumi_i = 1'b0;
        valid_i = 1'b0; is_store_op_i = 1'b0;
        check("hold done req", req_valid_o, 0);
        check("hold done busy", busy_o, 0);
        check("hold no wb", wb_valid_o, 0);
        tick();
        check("no accept at completion", req_valid_o, 0);

        // Response arriving together with yumi is ignored
        present(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 5'd4);
        req_yumi_i = 1'b1; resp_valid_i = 1'b1; resp_data_i = 32'h9999_9999;
        tick();
        req_yumi_i = 1'b0; resp_valid_i = 1'b0;
        check("same-cycle resp no wb", wb_valid_o, 0);
        check("same-cycle still busy", busy_o, 1);
        resp_valid_i = 1'b1; resp_data_i = 32'h1234_5678;
        tick();
        resp_valid_i = 1'b0;
        check("late resp wb", wb_valid_o, 1);
        check("late resp data", wb_data_o, 32'h1234_5678);

        // Request timeout: 256 cycles of req_valid_o, then abort with err
        present(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 5'd5);
        n = 0;
        while (req_valid_o && n < 1000) begin
            tick();
            n++;
        end
        check("req timeout cycles", n, 256);
        check("req timeout err", err_o, 1);
        check("req timeout busy", busy_o, 0);
        check("req timeout no wb", wb_valid_o, 0);
        tick();
        check("req timeout err pulse", err_o, 0);
        run_vec(vecs[6]);

        // Response timeout in WAIT_RESP
        present(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 5'd6);
        req_yumi_i = 1'b1;
        tick();
        req_yumi_i = 1'b0;
        n = 0;
        while (busy_o && n < 1000) begin
            tick();
            n++;
        end
        check("resp timeout cycles", n, 256);
        check("resp timeout err", err_o, 1);
        check("resp timeout no wb", wb_valid_o, 0);

        // Reset during WAIT_RESP drops the load
        tick();
        present(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 5'd8);
        req_yumi_i = 1'b1;
        tick();
        req_yumi_i = 1'b0;
        check("pre-reset busy", busy_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset busy", busy_o, 0);
        resp_valid_i = 1'b1; resp_data_i = 32'hFFFF_FFFF;
        tick();
        resp_valid_i = 1'b0;
        check("post reset busy", busy_o, 0);
        check("post reset no wb", wb_valid_o, 0);
        check("post reset no err", err_o, 0);
        check("post reset req", req_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
